// File: rtl/onetoeight_demux_collector.sv
// Sequential 1-to-WIDTH bit demultiplexer that assembles a word from a bit stream
// (addressed or auto-increment placement) and hands it off over valid/ready.
module onetoeight_demux_collector #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [SEL_W-1:0] din_sel,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             auto_mode,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] filled,
  output logic             dup
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] filled_q, filled_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             dup_q, dup_d;

  logic             acc;
  logic             use_auto;
  logic [SEL_W-1:0] pos;

  assign din_ready = (state_q != FULL);
  assign acc       = din_valid & din_ready;

  // Mode is sampled live only for the first bit of a word, then frozen.
  assign use_auto  = (state_q == IDLE) ? auto_mode : mode_q;
  assign pos       = use_auto ? cnt_q : din_sel;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    filled_d = filled_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    dup_d    = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (acc) begin
          mode_d        = use_auto;
          out_d[pos]    = din;
          filled_d[pos] = 1'b1;
          if (use_auto) begin
            cnt_d = cnt_q + SEL_W'(1);
          end else begin
            dup_d = filled_q[pos];
          end
        end
        if (&filled_d || (flush && state_q == COLLECT)) begin
          state_d = FULL;
        end else if (|filled_d) begin
          state_d = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d  = IDLE;
          out_d    = '0;
          filled_d = '0;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        out_d    = '0;
        filled_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      filled_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      dup_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      filled_q <= filled_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      dup_q    <= dup_d;
    end
  end

  assign out       = out_q;
  assign filled    = filled_q;
  assign out_valid = (state_q == FULL);
  assign dup       = dup_q;

endmodule

// File: tb/tb_onetoeight_demux_collector.sv
// Bench for onetoeight_demux_collector: directed scenarios plus random traffic
// against a bit-array reference model.
module tb_onetoeight_demux_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [2:0] din_sel;
  logic       din_valid;
  logic       din_ready;
  logic       auto_mode;
  logic       flush;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] filled;
  logic       dup;

  int npass = 0;
  int ntot  = 0;

  // reference model: word contents, written mask, auto position, latched mode
  bit [7:0] m_word;
  bit [7:0] m_mask;
  int       m_cnt;
  bit       m_auto;
  bit       m_full;
  bit       m_dup;

  always #5 clk = ~clk;

  onetoeight_demux_collector #(.WIDTH(8), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .din(din), .din_sel(din_sel),
    .din_valid(din_valid), .din_ready(din_ready),
    .auto_mode(auto_mode), .flush(flush),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .filled(filled), .dup(dup)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model(input bit r, input bit v, input bit d,
                       input int s, input bit a, input bit f,
                       input bit o);
    bit was_empty;
    int p;
    m_dup = 0;
    if (r) begin
      m_word = 0; m_mask = 0; m_cnt = 0; m_auto = 0; m_full = 0;
      return;
    end
    if (m_full) begin
      if (o) begin
        m_word = 0; m_mask = 0; m_cnt = 0; m_full = 0;
      end
      return;
    end
    was_empty = (m_mask == 0);
    if (v) begin
      if (was_empty) m_auto = a;
      p = m_auto ? m_cnt : s;
      if (!m_auto && m_mask[p]) m_dup = 1;
      m_word[p] = d;
      m_mask[p] = 1;
      if (m_auto) m_cnt = (m_cnt + 1) % 8;
    end
    if (m_mask == 8'hFF || (f && !was_empty)) m_full = 1;
  endtask

  task automatic step(input string tag, input bit r, input bit v,
                      input bit d, input int s, input bit a,
                      input bit f, input bit o);
    rst = r; din_valid = v; din = d; din_sel = 3'(s);
    auto_mode = a; flush = f; out_ready = o;
    model(r, v, d, s, a, f, o);
    @(posedge clk);
    #1;
    chk({tag, ".out"}, 32'(out), 32'(m_word));
    chk({tag, ".flags"}, {28'd0, out_valid, dup, din_ready, 1'b0},
        {28'd0, m_full, m_dup, !m_full, 1'b0});
    chk({tag, ".filled"}, 32'(filled), 32'(m_mask));
    @(negedge clk);
  endtask

  task automatic idle_step(input string tag, input bit o);
    step(tag, 0, 0, 0, 0, 0, 0, o);
  endtask

  initial begin
    bit [7:0] bits1;
    bit [7:0] held;
    rst = 1; din = 0; din_sel = 0; din_valid = 0;
    auto_mode = 0; flush = 0; out_ready = 0;
    @(negedge clk);
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    chk("reset.ready", 32'(din_ready), 32'd1);

    // 1: auto mode, 8 bits back-to-back
    bits1 = 8'b0100_1101;
    for (int i = 0; i < 8; i++)
      step("t1", 0, 1, bits1[i], 7 - i, 1, 0, 0);
    chk("t1.word", 32'(out), 32'h4D);
    chk("t1.valid", 32'(out_valid), 32'd1);
    step("t1.blocked", 0, 1, 1, 0, 1, 0, 0);
    chk("t1.notready", 32'(din_ready), 32'd0);
    step("t1.release", 0, 0, 0, 0, 0, 0, 1);

    // 2: addressed, sel 7..0, ones at 7,3,0
    for (int i = 7; i >= 0; i--)
      step("t2", 0, 1, (i == 7 || i == 3 || i == 0), i, 0, 0, 0);
    chk("t2.word", 32'(out), 32'h89);
    chk("t2.filled", 32'(filled), 32'hFF);
    step("t2.release", 0, 0, 0, 0, 0, 0, 1);
    chk("t2.cleared", {out, filled, 7'd0, din_ready}, 32'h1);

    // 3: duplicate addressed write
    step("t3.a", 0, 1, 1, 2, 0, 0, 0);
    step("t3.b", 0, 1, 0, 2, 0, 0, 0);
    chk("t3.dup", {dup, out, filled}, {1'b1, 8'h00, 8'h04});
    idle_step("t3.dupoff", 0);
    step("t3.flush", 0, 0, 0, 0, 0, 1, 0);
    step("t3.release", 0, 0, 0, 0, 0, 0, 1);

    // 4: three auto bits then flush
    for (int i = 0; i < 3; i++) step("t4", 0, 1, 1, 0, 1, 0, 0);
    step("t4.flush", 0, 0, 0, 0, 1, 1, 0);
    chk("t4.word", {out_valid, out}, {1'b1, 8'h07});

    // 5: hold output while din_valid is asserted
    held = out;
    for (int i = 0; i < 5; i++) step("t5.hold", 0, 1, 1, 5, 0, 0, 0);
    chk("t5.stable", 32'(out), 32'(held));
    step("t5.release", 0, 0, 0, 0, 0, 0, 1);
    step("t5.first", 0, 1, 1, 6, 1, 0, 0);
    step("t5.toggle", 0, 1, 1, 6, 0, 0, 0);
    chk("t5.modekept", 32'(filled), 32'h03);

    // 6: reset mid-word, then a clean word
    step("t6.a", 0, 1, 1, 0, 1, 0, 0);
    step("t6.b", 0, 1, 0, 0, 1, 0, 0);
    step("t6.rst", 1, 0, 0, 0, 0, 0, 0);
    chk("t6.zero", {out, filled, out_valid, dup}, 18'd0);
    for (int i = 0; i < 8; i++) step("t6.word", 0, 1, (i < 2), 0, 1, 0, 0);
    chk("t6.clean", 32'(out), 32'h03);
    step("t6.release", 0, 0, 0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 600; i++)
      step("rand", ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), $urandom_range(0, 7), 1'($urandom),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
